// File: rtl/execute_stage_fix.sv
// EX stage of the 5-stage ARMv8 pipeline: operand forwarding, ALU, branch target
// and the EX/MEM pipeline register.

module execute_stage_fix_fwd #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned REG_W    = 5,
  parameter int unsigned ZERO_REG = 31
) (
  input  logic [REG_W-1:0]  src,
  input  logic [DATA_W-1:0] rf_val,
  input  logic              mem_we,
  input  logic [REG_W-1:0]  mem_rd,
  input  logic [DATA_W-1:0] mem_val,
  input  logic              wb_we,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic [DATA_W-1:0] wb_val,
  output logic [DATA_W-1:0] fwd_val
);
  localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);

  // Younger producer (EX/MEM) wins over WB; XZR never forwards.
  always_comb begin
    fwd_val = rf_val;
    if (mem_we && (mem_rd == src) && (mem_rd != ZR))
      fwd_val = mem_val;
    else if (wb_we && (wb_rd == src) && (wb_rd != ZR))
      fwd_val = wb_val;
  end
endmodule

module execute_stage_fix #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned REG_W    = 5,
  parameter int unsigned ZERO_REG = 31
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              Flush_Ex,
  input  logic              Stall_Mem,
  input  logic              ALUSrc_Ex,
  input  logic [2:0]        ALUOp_Ex,
  input  logic              MemRead_Ex,
  input  logic              MemWrite_Ex,
  input  logic              MemtoReg_Ex,
  input  logic              RegWrite_Ex,
  input  logic [REG_W-1:0]  Rd_Ex,
  input  logic [REG_W-1:0]  Rn_Ex,
  input  logic [REG_W-1:0]  Rm_Ex,
  input  logic [DATA_W-1:0] SignExt_Ex,
  input  logic [DATA_W-1:0] ReadData1_Ex,
  input  logic [DATA_W-1:0] ReadData2_Ex,
  input  logic [DATA_W-1:0] PC_Ex,
  input  logic              RegWrite_Wb,
  input  logic [REG_W-1:0]  Rd_Wb,
  input  logic [DATA_W-1:0] WriteData_Wb,
  output logic [DATA_W-1:0] ALUResult_Mem,
  output logic [DATA_W-1:0] StoreData_Mem,
  output logic [DATA_W-1:0] BranchTarget_Mem,
  output logic              Zero_Mem,
  output logic [REG_W-1:0]  Rd_Mem,
  output logic              MemRead_Mem,
  output logic              MemWrite_Mem,
  output logic              MemtoReg_Mem,
  output logic              RegWrite_Mem
);
  localparam int NUM_SRC = 2;

  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] store;
    logic [DATA_W-1:0] bt;
    logic              zero;
    logic [REG_W-1:0]  rd;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              reg_write;
  } exmem_t;

  exmem_t ex_mem, ex_nxt;

  // Source 0 = Rn (operand A), source 1 = Rm (raw operand B / store data).
  logic [NUM_SRC-1:0][REG_W-1:0]  src_reg;
  logic [NUM_SRC-1:0][DATA_W-1:0] src_rf;
  logic [NUM_SRC-1:0][DATA_W-1:0] src_fwd;

  assign src_reg = {Rm_Ex, Rn_Ex};
  assign src_rf  = {ReadData2_Ex, ReadData1_Ex};

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
    execute_stage_fix_fwd #(
      .DATA_W(DATA_W), .REG_W(REG_W), .ZERO_REG(ZERO_REG)
    ) u_fwd (
      .src    (src_reg[i]),
      .rf_val (src_rf[i]),
      .mem_we (ex_mem.reg_write),
      .mem_rd (ex_mem.rd),
      .mem_val(ex_mem.alu),
      .wb_we  (RegWrite_Wb),
      .wb_rd  (Rd_Wb),
      .wb_val (WriteData_Wb),
      .fwd_val(src_fwd[i])
    );
  end

  logic [DATA_W-1:0] op_a, op_b, alu_res;

  assign op_a = src_fwd[0];
  assign op_b = ALUSrc_Ex ? SignExt_Ex : src_fwd[1];

  always_comb begin
    alu_res = op_a + op_b;
    unique case (ALUOp_Ex)
      3'b001:  alu_res = op_a - op_b;
      3'b010:  alu_res = op_a & op_b;
      3'b011:  alu_res = op_a | op_b;
      3'b100:  alu_res = op_b;
      3'b101:  alu_res = op_a ^ op_b;
      3'b110:  alu_res = op_a;
      default: alu_res = op_a + op_b;
    endcase
  end

  // A flushed instruction keeps its data fields; only control and Rd are killed.
  always_comb begin
    ex_nxt            = '0;
    ex_nxt.alu        = alu_res;
    ex_nxt.store      = src_fwd[1];
    ex_nxt.bt         = PC_Ex + (SignExt_Ex << 2);
    ex_nxt.zero       = (alu_res == '0);
    if (!Flush_Ex) begin
      ex_nxt.rd         = Rd_Ex;
      ex_nxt.mem_read   = MemRead_Ex;
      ex_nxt.mem_write  = MemWrite_Ex;
      ex_nxt.mem_to_reg = MemtoReg_Ex;
      ex_nxt.reg_write  = RegWrite_Ex;
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset)
      ex_mem <= '0;
    else if (!Stall_Mem)
      ex_mem <= ex_nxt;
  end

  assign ALUResult_Mem    = ex_mem.alu;
  assign StoreData_Mem    = ex_mem.store;
  assign BranchTarget_Mem = ex_mem.bt;
  assign Zero_Mem         = ex_mem.zero;
  assign Rd_Mem           = ex_mem.rd;
  assign MemRead_Mem      = ex_mem.mem_read;
  assign MemWrite_Mem     = ex_mem.mem_write;
  assign MemtoReg_Mem     = ex_mem.mem_to_reg;
  assign RegWrite_Mem     = ex_mem.reg_write;
endmodule

// File: tb/tb_execute_stage_fix.sv
// Bench for execute_stage_fix: vector table through a scoreboard queue, plus
// hand-written stall / flush / async-reset sequences.

module tb_execute_stage_fix;
  logic        clk, Reset, Flush_Ex, Stall_Mem, ALUSrc_Ex;
  logic [2:0]  ALUOp_Ex;
  logic        MemRead_Ex, MemWrite_Ex, MemtoReg_Ex, RegWrite_Ex;
  logic [4:0]  Rd_Ex, Rn_Ex, Rm_Ex, Rd_Wb;
  logic [63:0] SignExt_Ex, ReadData1_Ex, ReadData2_Ex, PC_Ex, WriteData_Wb;
  logic        RegWrite_Wb;
  logic [63:0] ALUResult_Mem, StoreData_Mem, BranchTarget_Mem;
  logic        Zero_Mem;
  logic [4:0]  Rd_Mem;
  logic        MemRead_Mem, MemWrite_Mem, MemtoReg_Mem, RegWrite_Mem;

  execute_stage_fix dut (
    .clk(clk), .Reset(Reset), .Flush_Ex(Flush_Ex), .Stall_Mem(Stall_Mem),
    .ALUSrc_Ex(ALUSrc_Ex), .ALUOp_Ex(ALUOp_Ex),
    .MemRead_Ex(MemRead_Ex), .MemWrite_Ex(MemWrite_Ex),
    .MemtoReg_Ex(MemtoReg_Ex), .RegWrite_Ex(RegWrite_Ex),
    .Rd_Ex(Rd_Ex), .Rn_Ex(Rn_Ex), .Rm_Ex(Rm_Ex), .SignExt_Ex(SignExt_Ex),
    .ReadData1_Ex(ReadData1_Ex), .ReadData2_Ex(ReadData2_Ex), .PC_Ex(PC_Ex),
    .RegWrite_Wb(RegWrite_Wb), .Rd_Wb(Rd_Wb), .WriteData_Wb(WriteData_Wb),
    .ALUResult_Mem(ALUResult_Mem), .StoreData_Mem(StoreData_Mem),
    .BranchTarget_Mem(BranchTarget_Mem), .Zero_Mem(Zero_Mem), .Rd_Mem(Rd_Mem),
    .MemRead_Mem(MemRead_Mem), .MemWrite_Mem(MemWrite_Mem),
    .MemtoReg_Mem(MemtoReg_Mem), .RegWrite_Mem(RegWrite_Mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] alu;
    logic [63:0] store;
    logic [63:0] bt;
    logic        zero;
    logic [4:0]  rd;
    logic [3:0]  ctrl;   // {MemRead, MemWrite, MemtoReg, RegWrite}
  } out_t;

  typedef struct {
    out_t e;
    bit   dc;            // data fields don't-care (bubble)
  } sb_t;

  typedef struct {
    logic [2:0]  aluop;
    logic        alusrc;
    logic [3:0]  ctrl;
    logic [4:0]  rd, rn, rm;
    logic [63:0] simm, rd1, rd2, pc;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [63:0] wb_dat;
    logic        flush;
    logic [63:0] e_alu, e_store, e_bt;
    logic        e_zero;
    bit          dc;
  } vec_t;

  sb_t  sb[$];
  int   total = 0;
  int   bad   = 0;
  vec_t tv[19];

  localparam logic [63:0] NEG2 = 64'hFFFF_FFFF_FFFF_FFFE;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  task automatic push_exp(input out_t e, input bit dc);
    sb_t s;
    s.e  = e;
    s.dc = dc;
    sb.push_back(s);
  endtask

  task automatic check(input string nm);
    sb_t  s;
    out_t a;
    bit   ok;
    a = {ALUResult_Mem, StoreData_Mem, BranchTarget_Mem, Zero_Mem, Rd_Mem,
         MemRead_Mem, MemWrite_Mem, MemtoReg_Mem, RegWrite_Mem};
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty, got=%h", nm, a);
      return;
    end
    s  = sb.pop_front();
    ok = s.dc ? ({a.rd, a.ctrl} === {s.e.rd, s.e.ctrl}) : (a === s.e);
    if (!ok) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", nm, a, s.e);
    end
  endtask

  task automatic drive(input vec_t v);
    ALUSrc_Ex    = v.alusrc;
    ALUOp_Ex     = v.aluop;
    {MemRead_Ex, MemWrite_Ex, MemtoReg_Ex, RegWrite_Ex} = v.ctrl;
    Rd_Ex        = v.rd;
    Rn_Ex        = v.rn;
    Rm_Ex        = v.rm;
    SignExt_Ex   = v.simm;
    ReadData1_Ex = v.rd1;
    ReadData2_Ex = v.rd2;
    PC_Ex        = v.pc;
    RegWrite_Wb  = v.wb_we;
    Rd_Wb        = v.wb_rd;
    WriteData_Wb = v.wb_dat;
    Flush_Ex     = v.flush;
  endtask

  task automatic apply(input vec_t v, input string nm);
    out_t e;
    drive(v);
    e.alu   = v.e_alu;
    e.store = v.e_store;
    e.bt    = v.e_bt;
    e.zero  = v.e_zero;
    e.rd    = v.flush ? 5'd0 : v.rd;
    e.ctrl  = v.flush ? 4'd0 : v.ctrl;
    push_exp(e, v.dc);
    @(posedge clk); #1;
    check(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    out_t held;
    // aluop alusrc ctrl rd rn rm simm rd1 rd2 pc wb_we wb_rd wb_dat flush | alu store bt zero dc
    tv[0]  = '{3'd0, 1'b0, 4'b0001, 5'd20, 5'd2,  5'd1, 64'd0, 64'd5, 64'd7, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 64'd12, 64'd7, 64'd0, 1'b0, 1'b0};
    tv[1]  = '{3'd1, 1'b0, 4'b0001, 5'd3,  5'd20, 5'd1, 64'd0, 64'd0, 64'd7, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 64'd5, 64'd7, 64'd0, 1'b0, 1'b0};
    tv[2]  = '{3'd1, 1'b0, 4'b0001, 5'd3,  5'd20, 5'd1, 64'd0, 64'd0, 64'd7, 64'd0, 1'b1, 5'd20, 64'd100, 1'b0, 64'd93, 64'd7, 64'd0, 1'b0, 1'b0};
    tv[3]  = '{3'd0, 1'b0, 4'b0001, 5'd20, 5'd2,  5'd1, 64'd0, 64'd5, 64'd7, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 64'd12, 64'd7, 64'd0, 1'b0, 1'b0};
    tv[4]  = '{3'd1, 1'b0, 4'b0001, 5'd3,  5'd20, 5'd1, 64'd0, 64'd0, 64'd7, 64'd0, 1'b1, 5'd20, 64'd100, 1'b0, 64'd5, 64'd7, 64'd0, 1'b0, 1'b0};
    tv[5]  = '{3'd0, 1'b0, 4'b0001, 5'd31, 5'd2,  5'd1, 64'd0, 64'd5, 64'd7, 64'd0, 1'b1, 5'd31, 64'd100, 1'b0, 64'd12, 64'd7, 64'd0, 1'b0, 1'b0};
    tv[6]  = '{3'd6, 1'b0, 4'b0001, 5'd3,  5'd31, 5'd1, 64'd0, 64'd0, 64'd7, 64'd0, 1'b1, 5'd31, 64'd100, 1'b0, 64'd0, 64'd7, 64'd0, 1'b1, 1'b0};
    tv[7]  = '{3'd0, 1'b1, 4'b0100, 5'd0,  5'd5,  5'd6, 64'd8, 64'h1000, 64'hAA, 64'h100, 1'b1, 5'd6, 64'h55, 1'b0, 64'h1008, 64'h55, 64'h120, 1'b0, 1'b0};
    tv[8]  = '{3'd6, 1'b0, 4'b0000, 5'd0,  5'd7,  5'd8, NEG2, 64'd0, 64'h11, 64'h40, 1'b0, 5'd0, 64'd0, 1'b0, 64'd0, 64'h11, 64'h38, 1'b1, 1'b0};
    tv[9]  = '{3'd6, 1'b0, 4'b0000, 5'd0,  5'd7,  5'd8, NEG2, 64'd3, 64'h11, 64'h40, 1'b0, 5'd0, 64'd0, 1'b0, 64'd3, 64'h11, 64'h38, 1'b0, 1'b0};
    tv[10] = '{3'd2, 1'b0, 4'b0000, 5'd0,  5'd2,  5'd1, 64'd0, 64'hF0F0, 64'hFF00, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 64'hF000, 64'hFF00, 64'd0, 1'b0, 1'b0};
    tv[11] = '{3'd3, 1'b0, 4'b0000, 5'd0,  5'd2,  5'd1, 64'd0, 64'hF0F0, 64'hFF00, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 64'hFFF0, 64'hFF00, 64'd0, 1'b0, 1'b0};
    tv[12] = '{3'd5, 1'b0, 4'b0000, 5'd0,  5'd2,  5'd1, 64'd0, 64'hF0F0, 64'hFF00, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 64'h0FF0, 64'hFF00, 64'd0, 1'b0, 1'b0};
    tv[13] = '{3'd4, 1'b0, 4'b0000, 5'd0,  5'd2,  5'd1, 64'd0, 64'hF0F0, 64'hFF00, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 64'hFF00, 64'hFF00, 64'd0, 1'b0, 1'b0};
    tv[14] = '{3'd7, 1'b0, 4'b0000, 5'd0,  5'd2,  5'd1, 64'd0, 64'hF0F0, 64'hFF00, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 64'h1EFF0, 64'hFF00, 64'd0, 1'b0, 1'b0};
    tv[15] = '{3'd1, 1'b0, 4'b0000, 5'd0,  5'd2,  5'd1, 64'd0, 64'd0, 64'd1, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, ONES, 64'd1, 64'd0, 1'b0, 1'b0};
    tv[16] = '{3'd0, 1'b0, 4'b0001, 5'd9,  5'd2,  5'd1, 64'd0, 64'd5, 64'd7, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 64'd12, 64'd7, 64'd0, 1'b0, 1'b1};
    tv[17] = '{3'd0, 1'b0, 4'b0001, 5'd9,  5'd2,  5'd1, 64'd0, 64'd5, 64'd7, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 64'd12, 64'd7, 64'd0, 1'b0, 1'b0};
    tv[18] = '{3'd0, 1'b0, 4'b0001, 5'd4,  5'd2,  5'd9, 64'd0, 64'd5, 64'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 64'd17, 64'd12, 64'd0, 1'b0, 1'b0};

    drive(tv[0]);
    Flush_Ex  = 1'b0;
    Stall_Mem = 1'b0;
    Reset     = 1'b0;
    #1 Reset  = 1'b1;
    #1;
    push_exp('0, 1'b0);
    check("reset_async");
    @(posedge clk); #1;
    push_exp('0, 1'b0);
    check("reset_held");
    Reset = 1'b0;

    for (int i = 0; i < 19; i++) apply(tv[i], $sformatf("vec%0d", i));

    // Stall holds the last result (ADD X4 = 17, store 12) while inputs change.
    held = {64'd17, 64'd12, 64'd0, 1'b0, 5'd4, 4'b0001};
    Stall_Mem = 1'b1;
    drive(tv[3]);
    for (int c = 0; c < 2; c++) begin
      push_exp(held, 1'b0);
      @(posedge clk); #1;
      check($sformatf("stall%0d", c));
    end
    Flush_Ex = 1'b1;
    push_exp(held, 1'b0);
    @(posedge clk); #1;
    check("stall_over_flush");

    // Reset mid-stall clears without a clock edge.
    #2 Reset = 1'b1;
    #1;
    push_exp('0, 1'b0);
    check("reset_mid_stall");
    @(posedge clk); #1;
    push_exp('0, 1'b0);
    check("reset_mid_stall_edge");
    Reset     = 1'b0;
    Stall_Mem = 1'b0;
    apply(tv[0], "post_reset_add");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
